alu_ctrl_issue: RTL and testbench
=================================

# alu_ctrl_issue

Sequential issue and control stage that drives the single-cycle datapath's 32-bit ALU from the operand side. It accepts a decoded instruction's ALUOp/funct fields and register operands over a valid/ready handshake, generates the 4-bit ALU select code, and presents registered operands and select to the ALU. It then captures the ALU result and zero flag into an output register held under a second valid/ready handshake. The block sits between the register-file read stage and the writeback/branch logic.

## Interface

- DATA_W, 32, operand/result width
- CNT_W, 16, completed-operation counter width

- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  upstream request valid
- o_ready  output  1  block can accept request this cycle
- i_alu_op  input  2  ALUOp: 00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 illegal
- i_funct  input  6  instruction funct field
- i_rs_data  input  DATA_W  operand A
- i_rt_data  input  DATA_W  operand B
- o_sel  output  4  ALU select, registered
- o_rd1  output  DATA_W  ALU operand A, registered
- o_rd2  output  DATA_W  ALU operand B, registered
- i_alu_result  input  DATA_W  combinational ALU result
- i_alu_zero  input  1  combinational ALU zero flag
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_result  output  DATA_W  captured ALU result
- o_zero  output  1  captured zero flag
- o_illegal  output  1  captured request had an undefined ALUOp/funct
- o_op_count  output  CNT_W  completed output handshakes, wraps

## Operation

- Select decode: ALUOp 00 -> 0010; 01 -> 0110; 10 with funct 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt), 100111 -> 1100 (nor).
- Any other funct under ALUOp 10, or ALUOp 11: o_sel = 1111, illegal flag set. The ALU returns 0 for 1111, so o_result = 0 and o_zero = 1. Both values are captured normally.
- FSM states:
  - IDLE: o_ready = 1, o_valid = 0.
  - EXEC: operands and select drive the ALU. o_ready = 0. Always moves to DONE on the next edge, capturing i_alu_result, i_alu_zero and the illegal flag.
  - DONE: o_valid = 1. Result registers are held stable.
- Request accept (IDLE or DONE) when i_valid & o_ready:
  - register i_rs_data -> o_rd1, i_rt_data -> o_rd2, and the decoded select -> o_sel;
  - go to EXEC.
- o_ready = (state == IDLE) | (state == DONE & i_ready). This allows a new request in the same cycle the previous result is consumed.
- DONE with i_ready = 1 and no new request -> IDLE. DONE with i_ready = 0 -> stay in DONE. o_result, o_zero and o_illegal hold, and no new request is accepted.
- o_op_count increments by 1 on each o_valid & i_ready cycle. It wraps from 2^CNT_W-1 to 0.
- The block does no arithmetic itself. Widths pass through unchanged.

## Timing

- Reset (i_rst high at an edge):
  - state IDLE;
  - o_sel = 0000, o_rd1 = o_rd2 = 0;
  - o_result = 0, o_zero = 0, o_illegal = 0, o_valid = 0, o_op_count = 0.
  - Reset overrides any handshake in the same cycle. An in-flight request is discarded and not counted.
- Latency: request accepted at edge N. o_sel/o_rd1/o_rd2 are valid during cycle N+1 (EXEC). o_valid rises after edge N+1 and is first sampled at edge N+2.
- Throughput: one result per 2 cycles under continuous i_valid with i_ready held at 1.
- Input fields are sampled only at the accept edge. Later changes to i_alu_op, i_funct or operands do not affect an in-flight operation.
- i_alu_result/i_alu_zero are sampled only at the EXEC->DONE edge.
- In DONE, o_sel/o_rd1/o_rd2 keep their last values until the next accept.

## Test plan

- Reset then ALUOp 10, funct 100000, rs = 5, rt = 7:
  - o_sel = 0010 in cycle N+1;
  - o_valid at N+2 with o_result = 12, o_zero = 0;
  - o_op_count = 1 after the handshake.
- ALUOp 01, rs = rt = 0x1234: o_sel = 0110, o_result = 0, o_zero = 1 (beq taken).
- Decode sweep: ALUOp 00 -> 0010. Funct 100100/100101/101010/100111 with rs = 0xF0, rt = 0x0F must give:
  - o_sel 0000/0001/0111/1100;
  - o_result 0x00/0xFF/0/0xFFFFFF00.
- Illegal inputs (ALUOp 11, and ALUOp 10 with funct 000000): o_sel = 1111, o_illegal = 1, o_result = 0, o_zero = 1.
- Backpressure:
  - hold i_ready = 0 for 5 cycles in DONE: o_valid stays 1, o_result stable, o_ready = 0;
  - raise i_ready with i_valid = 1: new request accepted the same cycle, next state EXEC.
- Assert i_rst during EXEC: all outputs return to reset values next cycle and o_op_count does not increment. Separately, preload 0xFFFF handshakes so one more wraps o_op_count to 0.

Source files
------------

// File: rtl/alu_ctrl_issue_if.sv
// Bundle of signals between alu_ctrl_issue and the blocks around it.
// It carries the upstream request channel, the ALU operand and result
// path, and the downstream result channel.
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. The sender keeps valid and its
// payload stable until that edge. Ready may depend combinationally on
// the other side's ready, but never on valid.
interface alu_ctrl_issue_if #(
  parameter int DATA_W = 32
);
  // upstream request channel
  logic              i_valid;
  logic              o_ready;
  logic [1:0]        i_alu_op;
  logic [5:0]        i_funct;
  logic [DATA_W-1:0] i_rs_data;
  logic [DATA_W-1:0] i_rt_data;
  // ALU side
  logic [3:0]        o_sel;
  logic [DATA_W-1:0] o_rd1;
  logic [DATA_W-1:0] o_rd2;
  logic [DATA_W-1:0] i_alu_result;
  logic              i_alu_zero;
  // downstream result channel
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_result;
  logic              o_zero;
  logic              o_illegal;

  // the issue block itself
  modport slave (
    input  i_valid, i_alu_op, i_funct, i_rs_data, i_rt_data,
    input  i_alu_result, i_alu_zero, i_ready,
    output o_ready, o_sel, o_rd1, o_rd2,
    output o_valid, o_result, o_zero, o_illegal
  );

  // the surroundings: register-file read, ALU and writeback
  modport master (
    output i_valid, i_alu_op, i_funct, i_rs_data, i_rt_data,
    output i_alu_result, i_alu_zero, i_ready,
    input  o_ready, o_sel, o_rd1, o_rd2,
    input  o_valid, o_result, o_zero, o_illegal
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ALU issue and control stage. It decodes ALUOp/funct into a 4-bit ALU
// select and registers the operands and select towards the ALU. One
// cycle later it captures the ALU result and zero flag into a result
// register, which it holds until the downstream side takes it.
module alu_ctrl_issue #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_ctrl_issue_if.slave  bus,
  output logic [CNT_W-1:0] o_op_count,
  output logic [1:0]       o_state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
  localparam logic [3:0] SEL_BAD = 4'b1111;

  logic [1:0]        state_q, state_d;
  logic              ready, accept, handshake;
  logic [3:0]        sel_dec;
  logic              ill_dec;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, result_q;
  logic              zero_q, ill_pend_q, ill_q;
  logic [CNT_W-1:0]  cnt_q;

  // Decode ALUOp/funct into the ALU select. Anything undefined maps to
  // the all-ones select, for which the ALU returns 0.
  always_comb begin
    sel_dec = SEL_BAD;
    ill_dec = 1'b1;
    case (bus.i_alu_op)
      2'b00: begin sel_dec = SEL_ADD; ill_dec = 1'b0; end
      2'b01: begin sel_dec = SEL_SUB; ill_dec = 1'b0; end
      2'b10: begin
        case (bus.i_funct)
          6'b100000: begin sel_dec = SEL_ADD; ill_dec = 1'b0; end
          6'b100010: begin sel_dec = SEL_SUB; ill_dec = 1'b0; end
          6'b100100: begin sel_dec = SEL_AND; ill_dec = 1'b0; end
          6'b100101: begin sel_dec = SEL_OR;  ill_dec = 1'b0; end
          6'b101010: begin sel_dec = SEL_SLT; ill_dec = 1'b0; end
          6'b100111: begin sel_dec = SEL_NOR; ill_dec = 1'b0; end
          default:   begin sel_dec = SEL_BAD; ill_dec = 1'b1; end
        endcase
      end
      default: begin sel_dec = SEL_BAD; ill_dec = 1'b1; end
    endcase
  end

  // Handshake qualifiers. Ready in DONE follows the downstream ready, so
  // a new request can enter in the same cycle the old result leaves.
  always_comb begin
    ready     = (state_q == IDLE) | ((state_q == DONE) & bus.i_ready);
    accept    = bus.i_valid & ready;
    handshake = (state_q == DONE) & bus.i_ready;
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: begin
        if (accept)           state_d = EXEC;
        else if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand/select register, loaded only at the accept edge. The illegal
  // flag waits here until the result is captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q      <= 4'b0000;
      rd1_q      <= '0;
      rd2_q      <= '0;
      ill_pend_q <= 1'b0;
    end else if (accept) begin
      sel_q      <= sel_dec;
      rd1_q      <= bus.i_rs_data;
      rd2_q      <= bus.i_rt_data;
      ill_pend_q <= ill_dec;
    end
  end

  // Result register, loaded only on the EXEC -> DONE edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q <= bus.i_alu_result;
      zero_q   <= bus.i_alu_zero;
      ill_q    <= ill_pend_q;
    end
  end

  // Completed-result counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (i_rst)          cnt_q <= '0;
    else if (handshake) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = (state_q == DONE);
  assign bus.o_sel     = sel_q;
  assign bus.o_rd1     = rd1_q;
  assign bus.o_rd2     = rd2_q;
  assign bus.o_result  = result_q;
  assign bus.o_zero    = zero_q;
  assign bus.o_illegal = ill_q;
  assign o_op_count    = cnt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue. It contains a behavioural ALU on the operand
// side and an instruction-level reference model. A second instance with
// a narrow counter exercises the counter wrap.
module tb_alu_ctrl_issue;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_issue_if #(.DATA_W(DATA_W)) bus ();
  alu_ctrl_issue_if #(.DATA_W(DATA_W)) bus2 ();
  logic [CNT_W-1:0] op_count;
  logic [1:0]       state_dbg;
  logic [3:0]       op_count2;
  logic [1:0]       state_dbg2;

  alu_ctrl_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_op_count(op_count), .o_state(state_dbg));
  alu_ctrl_issue #(.DATA_W(DATA_W), .CNT_W(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .bus(bus2), .o_op_count(op_count2), .o_state(state_dbg2));

  // behavioural single-cycle ALU driven by the registered select/operands
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.o_sel)
      4'b0010: alu_res = bus.o_rd1 + bus.o_rd2;
      4'b0110: alu_res = bus.o_rd1 - bus.o_rd2;
      4'b0000: alu_res = bus.o_rd1 & bus.o_rd2;
      4'b0001: alu_res = bus.o_rd1 | bus.o_rd2;
      4'b0111: alu_res = ($signed(bus.o_rd1) < $signed(bus.o_rd2)) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(bus.o_rd1 | bus.o_rd2);
      default: alu_res = '0;
    endcase
  end
  assign bus.i_alu_result  = alu_res;
  assign bus.i_alu_zero    = (alu_res == '0);
  assign bus2.i_alu_result = '0;
  assign bus2.i_alu_zero   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0]  exp_count;
  logic [DATA_W-1:0] exp_q[$];
  logic [5:0] legal_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

  // instruction meaning: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 nor, -1 undefined
  function automatic int ref_kind(input logic [1:0] op, input logic [5:0] funct);
    if (op == 2'd0) return 0;
    if (op == 2'd1) return 1;
    if (op == 2'd3) return -1;
    case (funct)
      6'd32: return 0;
      6'd34: return 1;
      6'd36: return 2;
      6'd37: return 3;
      6'd42: return 4;
      6'd39: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] ref_sel(input int kind);
    case (kind)
      0: return 4'd2;
      1: return 4'd6;
      2: return 4'd0;
      3: return 4'd1;
      4: return 4'd7;
      5: return 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] ref_result(input int kind, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (kind)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.i_valid = 1'b0; bus.i_alu_op = 2'b00; bus.i_funct = 6'd0;
    bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_ready = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_alu_op = 2'b00; bus2.i_funct = 6'd0;
    bus2.i_rs_data = '0; bus2.i_rt_data = '0; bus2.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    exp_count = '0;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", bus.o_ready); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.o_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_sel: got %b exp 0000", bus.o_sel); end
    n_checks++; if (bus.o_rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_rd1: got %h exp 0", bus.o_rd1); end
    n_checks++; if (bus.o_rd2 !== 32'd0) begin n_fail++; $display("FAIL reset_rd2: got %h exp 0", bus.o_rd2); end
    n_checks++; if (bus.o_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", bus.o_result); end
    n_checks++; if (bus.o_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b exp 0", bus.o_zero); end
    n_checks++; if (bus.o_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b exp 0", bus.o_illegal); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL reset_count: got %0d exp %0d", op_count, exp_count); end
    rst = 1'b0;
  endtask

  // One full request/result transaction with checks at each stage
  task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] funct,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int kind;
    logic [3:0] es;
    logic [DATA_W-1:0] er;
    bit ok;
    kind = ref_kind(op, funct);
    es = ref_sel(kind);
    er = ref_result(kind, a, b);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = op; bus.i_funct = funct;
    bus.i_rs_data = a; bus.i_rt_data = b; bus.i_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.o_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_accept: o_ready stayed %b", name, bus.o_ready); bus.i_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (bus.o_sel !== es) begin n_fail++; $display("FAIL %s_sel: got %b exp %b", name, bus.o_sel, es); end
    n_checks++; if (bus.o_rd1 !== a || bus.o_rd2 !== b) begin n_fail++; $display("FAIL %s_operands: got %h/%h exp %h/%h", name, bus.o_rd1, bus.o_rd2, a, b); end
    n_checks++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL %s_exec_flags: got ready %b valid %b exp 0 0", name, bus.o_ready, bus.o_valid); end
    // inputs change while in flight; they must not leak into the result
    bus.i_valid = 1'b0; bus.i_alu_op = 2'($urandom_range(0, 3)); bus.i_funct = 6'($urandom);
    bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
    @(negedge clk); #1;
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b exp 1", name, bus.o_valid); end
    n_checks++; if (bus.o_result !== er) begin n_fail++; $display("FAIL %s_result: got %h exp %h", name, bus.o_result, er); end
    n_checks++; if (bus.o_zero !== (er == '0)) begin n_fail++; $display("FAIL %s_zero: got %b exp %b", name, bus.o_zero, (er == '0)); end
    n_checks++; if (bus.o_illegal !== (kind < 0)) begin n_fail++; $display("FAIL %s_illegal: got %b exp %b", name, bus.o_illegal, (kind < 0)); end
    n_checks++; if (bus.o_sel !== es) begin n_fail++; $display("FAIL %s_sel_hold: got %b exp %b", name, bus.o_sel, es); end
    bus.i_ready = 1'b1;
    @(negedge clk); #1;
    exp_count = exp_count + 1'b1;
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL %s_count: got %0d exp %0d", name, op_count, exp_count); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL %s_release: got valid %b exp 0", name, bus.o_valid); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_op("add_5_7", 2'b10, 6'b100000, 32'd5, 32'd7);
    run_op("beq_equal", 2'b01, 6'($urandom), 32'h1234, 32'h1234);
  endtask

  task automatic test_decode_sweep();
    run_op("lw_add", 2'b00, 6'($urandom), $urandom, $urandom);
    run_op("r_and", 2'b10, 6'b100100, 32'hF0, 32'h0F);
    run_op("r_or", 2'b10, 6'b100101, 32'hF0, 32'h0F);
    run_op("r_slt", 2'b10, 6'b101010, 32'hF0, 32'h0F);
    run_op("r_nor", 2'b10, 6'b100111, 32'hF0, 32'h0F);
    run_op("r_sub", 2'b10, 6'b100010, $urandom, $urandom);
    run_op("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFE, 32'd3);
  endtask

  task automatic test_illegal();
    run_op("op11", 2'b11, 6'b100000, 32'd9, 32'd9);
    run_op("funct0", 2'b10, 6'b000000, $urandom, $urandom);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = legal_funct[$urandom_range(0, 5)];
      run_op("rand", 2'($urandom_range(0, 3)), f, $urandom, $urandom);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a1, b1, a2, b2, er1, er2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    er1 = ref_result(ref_kind(2'b10, 6'b100010), a1, b1);
    er2 = ref_result(ref_kind(2'b10, 6'b100101), a2, b2);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = 2'b10; bus.i_funct = 6'b100010;
    bus.i_rs_data = a1; bus.i_rt_data = b1; bus.i_ready = 1'b0;
    #1;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %b exp 1", bus.o_ready); end
    @(negedge clk);
    // second request already waiting upstream during the stall
    bus.i_alu_op = 2'b10; bus.i_funct = 6'b100101; bus.i_rs_data = a2; bus.i_rt_data = b2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b exp 1", c, bus.o_valid); end
      n_checks++; if (bus.o_result !== er1) begin n_fail++; $display("FAIL bp_result_c%0d: got %h exp %h", c, bus.o_result, er1); end
      n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b exp 0", c, bus.o_ready); end
      n_checks++; if (bus.o_sel !== ref_sel(1)) begin n_fail++; $display("FAIL bp_sel_c%0d: got %b exp %b", c, bus.o_sel, ref_sel(1)); end
    end
    bus.i_ready = 1'b1;
    #1;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", bus.o_ready); end
    @(negedge clk); #1;
    exp_count = exp_count + 1'b1;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_exec: got valid %b ready %b exp 0 0", bus.o_valid, bus.o_ready); end
    n_checks++; if (bus.o_sel !== ref_sel(3) || bus.o_rd1 !== a2) begin n_fail++; $display("FAIL bp_new_issue: got sel %b rd1 %h exp %b %h", bus.o_sel, bus.o_rd1, ref_sel(3), a2); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", op_count, exp_count); end
    @(negedge clk); #1;
    n_checks++; if (bus.o_result !== er2) begin n_fail++; $display("FAIL bp_result2: got %h exp %h", bus.o_result, er2); end
    bus.i_ready = 1'b1;
    @(negedge clk); #1;
    exp_count = exp_count + 1'b1;
    bus.i_ready = 1'b0;
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL bp_count2: got %0d exp %0d", op_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int done = 0;
    int last_hs = -1;
    bit acc;
    logic [DATA_W-1:0] exp;
    exp_q.delete();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    bus.i_alu_op = 2'($urandom_range(0, 2)); bus.i_funct = legal_funct[$urandom_range(0, 5)];
    bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
    for (int cyc = 0; cyc < 60 && done < 8; cyc++) begin
      #1;
      if (bus.o_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected: result %h with nothing outstanding", bus.o_result); end
        else begin
          exp = exp_q.pop_front();
          if (bus.o_result !== exp) begin n_fail++; $display("FAIL b2b_result: got %h exp %h", bus.o_result, exp); end
        end
        if (last_hs >= 0) begin
          n_checks++; if (cyc - last_hs != 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles exp 2", cyc - last_hs); end
        end
        last_hs = cyc;
        done++;
        exp_count = exp_count + 1'b1;
      end
      acc = (bus.o_ready === 1'b1) && bus.i_valid;
      if (acc) exp_q.push_back(ref_result(ref_kind(bus.i_alu_op, bus.i_funct), bus.i_rs_data, bus.i_rt_data));
      @(negedge clk);
      if (acc) begin
        accepted++;
        if (accepted < 8) begin
          bus.i_alu_op = 2'($urandom_range(0, 2)); bus.i_funct = legal_funct[$urandom_range(0, 5)];
          bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
        end else bus.i_valid = 1'b0;
      end
    end
    bus.i_ready = 1'b0; bus.i_valid = 1'b0;
    #1;
    n_checks++; if (done != 8) begin n_fail++; $display("FAIL b2b_done: got %0d results exp 8", done); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %0d exp %0d", op_count, exp_count); end
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = 2'b00; bus.i_rs_data = 32'hAAAA; bus.i_rt_data = 32'h5555; bus.i_ready = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL rx_in_exec: got ready %b exp 0", bus.o_ready); end
    rst = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk); #1;
    exp_count = '0;
    n_checks++; if (bus.o_sel !== 4'b0000 || bus.o_rd1 !== 32'd0 || bus.o_rd2 !== 32'd0) begin n_fail++; $display("FAIL rx_operands: got %b %h %h exp 0000 0 0", bus.o_sel, bus.o_rd1, bus.o_rd2); end
    n_checks++; if (bus.o_result !== 32'd0 || bus.o_zero !== 1'b0 || bus.o_illegal !== 1'b0) begin n_fail++; $display("FAIL rx_result: got %h %b %b exp 0 0 0", bus.o_result, bus.o_zero, bus.o_illegal); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid: got %b exp 0", bus.o_valid); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL rx_count: got %0d exp %0d", op_count, exp_count); end
    rst = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bus.o_valid !== 1'b0 || op_count !== exp_count) begin n_fail++; $display("FAIL rx_discard: got valid %b count %0d exp 0 %0d", bus.o_valid, op_count, exp_count); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int k = 0;
    logic [3:0] exp4;
    @(negedge clk);
    bus2.i_valid = 1'b1; bus2.i_ready = 1'b1; bus2.i_alu_op = 2'b00;
    for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
      bit hs;
      #1;
      hs = (bus2.o_valid === 1'b1);
      if (k == 15 && hs) bus2.i_valid = 1'b0;
      @(negedge clk);
      if (hs) begin
        k++;
        exp4 = 4'(k);
        #1;
        n_checks++; if (op_count2 !== exp4) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d exp %0d", k, op_count2, exp4); end
      end
    end
    bus2.i_valid = 1'b0; bus2.i_ready = 1'b0;
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL wrap_done: got %0d handshakes exp 16", k); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    exp_count = '0;
    drive_idle();
    test_reset();
    test_directed();
    test_decode_sweep();
    test_illegal();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_exec();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("debug state at end: %0d %0d", state_dbg, state_dbg2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
